// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register with valid/ready handshake, optional 2-entry skid,
// synchronous flush and saturating stall/bubble counters.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CTRL_W     = 16,
  parameter bit          SKID       = 1'b1,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e              state_q;
  logic [DATA_W-1:0]   main_data_q, skid_data_q;
  logic [CTRL_W-1:0]   main_ctrl_q, skid_ctrl_q;
  logic [CNT_W-1:0]    stall_q, bubble_q;
  logic                in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_data_q;
  // Holding registers keep stale ctrl after a normal drain; mask it while empty.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;

  if (SKID) begin : g_skid
    assign in_ready = !rst && (state_q != StSkid);
  end else begin : g_single
    assign in_ready = !rst && (!out_valid || out_ready);
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      if (CLEAR_DATA) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_q     <= StFull;
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end
        end
        StFull: begin
          if (in_fire && out_fire) begin
            main_data_q <= in_data;
            main_ctrl_q <= in_ctrl;
          end else if (in_fire) begin
            // Only reachable with SKID=1: downstream stalled, park the new beat.
            state_q     <= StSkid;
            skid_data_q <= in_data;
            skid_ctrl_q <= in_ctrl;
          end else if (out_fire) begin
            state_q <= StEmpty;
          end
        end
        StSkid: begin
          if (out_fire) begin
            state_q     <= StFull;
            main_data_q <= skid_data_q;
            main_ctrl_q <= skid_ctrl_q;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else if (cnt_clr) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_q != CntMax)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (!out_valid && (bubble_q != CntMax)) begin
        bubble_q <= bubble_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and randomised checks of pipe_stage_elastic in skid (4-bit counters) and
// single-entry (CLEAR_DATA=0) configurations sharing one stimulus stream.
module tb_pipe_stage_elastic;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, cnt_clr;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [15:0] a_out_ctrl;
  logic [3:0]  a_stall, a_bubble;

  logic        b_in_ready, b_out_valid;
  logic [31:0] b_out_data;
  logic [15:0] b_out_ctrl;
  logic [15:0] b_stall, b_bubble;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .DATA_W(32), .CTRL_W(16), .SKID(1'b1), .CLEAR_DATA(1'b1), .CNT_W(4)
  ) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .cnt_clr(cnt_clr),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  pipe_stage_elastic #(
    .DATA_W(32), .CTRL_W(16), .SKID(1'b0), .CLEAR_DATA(1'b0), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl), .cnt_clr(cnt_clr),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; cnt_clr = 1'b0;
    in_data = 32'h0; in_ctrl = 16'h0;
    repeat (2) tick();
    n_vec++;
    if ({a_out_valid, a_out_data, a_out_ctrl} !== 49'h0) begin
      n_err++; $display("FAIL reset_outputs: got %0h want 0", {a_out_valid, a_out_data, a_out_ctrl});
    end
    n_vec++;
    if ({a_in_ready, b_in_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_in_ready: got %b want 00", {a_in_ready, b_in_ready});
    end
    n_vec++;
    if ({a_stall, a_bubble, b_stall, b_bubble} !== 40'h0) begin
      n_err++; $display("FAIL reset_counters: got %0h/%0h want 0/0", a_stall, a_bubble);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({a_in_ready, b_in_ready} !== 2'b11) begin
      n_err++; $display("FAIL post_reset_in_ready: got %b want 11", {a_in_ready, b_in_ready});
    end
  endtask

  task automatic test_throughput;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'h11 + i;
      in_ctrl = 16'h0100 + 16'(i);
      tick();
      n_vec++;
      if ({a_out_valid, a_out_data, a_out_ctrl} !== {1'b1, 32'h11 + i, 16'h0100 + 16'(i)}) begin
        n_err++; $display("FAIL thru_a[%0d]: got v=%b d=%0h want v=1 d=%0h",
                          i, a_out_valid, a_out_data, 32'h11 + i);
      end
      n_vec++;
      if ({b_out_valid, b_out_data} !== {1'b1, 32'h11 + i}) begin
        n_err++; $display("FAIL thru_b[%0d]: got v=%b d=%0h want v=1 d=%0h",
                          i, b_out_valid, b_out_data, 32'h11 + i);
      end
    end
    in_valid = 1'b0;
    tick();
    n_vec++;
    if ({a_out_valid, b_out_valid, a_out_ctrl} !== 18'h0) begin
      n_err++; $display("FAIL thru_drain: got va=%b vb=%b ctrl=%0h want 0 0 0",
                        a_out_valid, b_out_valid, a_out_ctrl);
    end
  endtask

  task automatic test_skid;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA; in_ctrl = 16'h000A;
    tick();
    in_data   = 32'hB; in_ctrl = 16'h000B;
    tick();
    in_valid  = 1'b0;
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL skid_in_ready: got %b want 0", a_in_ready);
    end
    tick();
    n_vec++;
    if ({a_out_valid, a_out_data} !== {1'b1, 32'hA}) begin
      n_err++; $display("FAIL skid_hold: got v=%b d=%0h want v=1 d=a", a_out_valid, a_out_data);
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if ({a_out_valid, a_out_data, a_in_ready} !== {1'b1, 32'hB, 1'b1}) begin
      n_err++; $display("FAIL skid_second: got v=%b d=%0h rdy=%b want v=1 d=b rdy=1",
                        a_out_valid, a_out_data, a_in_ready);
    end
    tick();
    n_vec++;
    if (a_out_valid !== 1'b0) begin
      n_err++; $display("FAIL skid_empty: got %b want 0", a_out_valid);
    end
  endtask

  task automatic test_flush_skid;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'h00FF;
    in_data   = 32'h1;
    tick();
    in_data   = 32'h2;
    tick();
    flush     = 1'b1;
    in_data   = 32'h3;
    #1;
    n_vec++;
    if (a_in_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_in_ready_during: got %b want 0", a_in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if ({a_out_valid, a_out_ctrl, a_out_data, a_in_ready} !== {1'b0, 16'h0, 32'h0, 1'b1}) begin
      n_err++; $display("FAIL flush_skid: got v=%b c=%0h d=%0h rdy=%b want 0 0 0 1",
                        a_out_valid, a_out_ctrl, a_out_data, a_in_ready);
    end
    n_vec++;
    if ({b_out_valid, b_out_ctrl, b_out_data} !== {1'b0, 16'h0, 32'h1}) begin
      n_err++; $display("FAIL flush_b_hold: got v=%b c=%0h d=%0h want 0 0 1",
                        b_out_valid, b_out_ctrl, b_out_data);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({a_out_valid, b_out_valid} !== 2'b00) begin
      n_err++; $display("FAIL flush_discard: got %b want 00", {a_out_valid, b_out_valid});
    end
  endtask

  task automatic test_flush_keep_data;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD; in_ctrl = 16'h1234;
    tick();
    in_valid  = 1'b0;
    n_vec++;
    if ({b_out_valid, b_out_data, b_out_ctrl} !== {1'b1, 32'hDEAD, 16'h1234}) begin
      n_err++; $display("FAIL keep_load: got v=%b d=%0h c=%0h want 1 dead 1234",
                        b_out_valid, b_out_data, b_out_ctrl);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++;
    if ({b_out_valid, b_out_ctrl, b_out_data} !== {1'b0, 16'h0, 32'hDEAD}) begin
      n_err++; $display("FAIL keep_flush: got v=%b c=%0h d=%0h want 0 0 dead",
                        b_out_valid, b_out_ctrl, b_out_data);
    end
    n_vec++;
    if ({a_out_valid, a_out_data} !== 33'h0) begin
      n_err++; $display("FAIL clear_flush_a: got v=%b d=%0h want 0 0", a_out_valid, a_out_data);
    end
  endtask

  task automatic test_counters;
    out_ready = 1'b0;
    cnt_clr   = 1'b1;
    tick();
    cnt_clr   = 1'b0;
    n_vec++;
    if ({a_stall, a_bubble} !== 8'h00) begin
      n_err++; $display("FAIL cnt_clear0: got %0h/%0h want 0/0", a_stall, a_bubble);
    end
    in_valid = 1'b1; in_data = 32'h77; in_ctrl = 16'h7;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    n_vec++;
    if (a_stall !== 4'd14) begin
      n_err++; $display("FAIL cnt_stall14: got %0d want 14", a_stall);
    end
    repeat (6) tick();
    n_vec++;
    if ({a_stall, a_bubble} !== {4'd15, 4'd1}) begin
      n_err++; $display("FAIL cnt_saturate: got %0d/%0d want 15/1", a_stall, a_bubble);
    end
    n_vec++;
    if (b_stall !== 16'd20) begin
      n_err++; $display("FAIL cnt_b_stall: got %0d want 20", b_stall);
    end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_vec++;
    if ({a_stall, a_bubble} !== 8'h00) begin
      n_err++; $display("FAIL cnt_clear_prio: got %0d/%0d want 0/0", a_stall, a_bubble);
    end
    tick();
    n_vec++;
    if (a_stall !== 4'd1) begin
      n_err++; $display("FAIL cnt_restart: got %0d want 1", a_stall);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 32'h55; in_ctrl = 16'h5;
    tick();
    in_valid  = 1'b0;
    n_vec++;
    if (a_out_valid !== 1'b1) begin
      n_err++; $display("FAIL arst_pre: got %b want 1", a_out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({a_out_valid, a_out_data, a_out_ctrl, a_in_ready, b_out_valid} !== 51'h0) begin
      n_err++; $display("FAIL arst_immediate: got v=%b d=%0h c=%0h rdy=%b vb=%b want all 0",
                        a_out_valid, a_out_data, a_out_ctrl, a_in_ready, b_out_valid);
    end
    n_vec++;
    if (a_stall !== 4'd0) begin
      n_err++; $display("FAIL arst_counter: got %0d want 0", a_stall);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_soak;
    logic [47:0] qa[$];
    logic [47:0] qb[$];
    logic [47:0] ha, hb;
    logic        ha_v, hb_v;
    ha_v = 1'b0; hb_v = 1'b0; ha = '0; hb = '0;
    for (int c = 0; c < 420; c++) begin
      @(posedge clk);
      #1;
      if (c < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      in_data = $urandom;
      in_ctrl = in_data[15:0] ^ 16'hA5A5;
      #2;
      // Skid configuration
      if (ha_v) begin
        n_vec++;
        if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, ha}) begin
          n_err++; $display("FAIL soak_a_stable[%0d]: got %0h want %0h",
                            c, {a_out_ctrl, a_out_data}, ha);
        end
      end
      n_vec++;
      if ({a_out_valid, a_in_ready} !== {qa.size() != 0, qa.size() < 2}) begin
        n_err++; $display("FAIL soak_a_occ[%0d]: got v=%b rdy=%b want entries=%0d",
                          c, a_out_valid, a_in_ready, qa.size());
      end
      if (a_out_valid && qa.size() != 0) begin
        n_vec++;
        if ({a_out_ctrl, a_out_data} !== qa[0]) begin
          n_err++; $display("FAIL soak_a_data[%0d]: got %0h want %0h",
                            c, {a_out_ctrl, a_out_data}, qa[0]);
        end
      end else if (!a_out_valid) begin
        n_vec++;
        if (a_out_ctrl !== 16'h0) begin
          n_err++; $display("FAIL soak_a_ctrl0[%0d]: got %0h want 0", c, a_out_ctrl);
        end
      end
      if (a_out_valid && out_ready && qa.size() != 0) void'(qa.pop_front());
      if (in_valid && a_in_ready) qa.push_back({in_ctrl, in_data});
      ha_v = a_out_valid && !out_ready;
      ha   = {a_out_ctrl, a_out_data};
      // Single-entry configuration
      if (hb_v) begin
        n_vec++;
        if ({b_out_valid, b_out_ctrl, b_out_data} !== {1'b1, hb}) begin
          n_err++; $display("FAIL soak_b_stable[%0d]: got %0h want %0h",
                            c, {b_out_ctrl, b_out_data}, hb);
        end
      end
      n_vec++;
      if ({b_out_valid, b_in_ready} !== {qb.size() != 0, (qb.size() == 0) || out_ready}) begin
        n_err++; $display("FAIL soak_b_occ[%0d]: got v=%b rdy=%b want entries=%0d",
                          c, b_out_valid, b_in_ready, qb.size());
      end
      if (b_out_valid && qb.size() != 0) begin
        n_vec++;
        if ({b_out_ctrl, b_out_data} !== qb[0]) begin
          n_err++; $display("FAIL soak_b_data[%0d]: got %0h want %0h",
                            c, {b_out_ctrl, b_out_data}, qb[0]);
        end
      end
      if (b_out_valid && out_ready && qb.size() != 0) void'(qb.pop_front());
      if (in_valid && b_in_ready) qb.push_back({in_ctrl, in_data});
      hb_v = b_out_valid && !out_ready;
      hb   = {b_out_ctrl, b_out_data};
    end
    n_vec++;
    if ({qa.size() == 0, qb.size() == 0, a_out_valid, b_out_valid} !== 4'b1100) begin
      n_err++; $display("FAIL soak_drain: got qa=%0d qb=%0d va=%b vb=%b want 0 0 0 0",
                        qa.size(), qb.size(), a_out_valid, b_out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_throughput();
    test_skid();
    test_flush_skid();
    test_flush_keep_data();
    test_counters();
    test_async_reset();
    test_soak();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
